usb_fs_rx_bit_recovery: RTL and testbench

- Full-speed USB receive front end, directly downstream of the D+/D- synchronizers and the transition-pulse edge detectors.
- Consumes the synchronized line levels plus a one-cycle transition pulse and recovers the bit clock with a 4x-oversampling phase counter.
- Produces line state, NRZI-decoded and de-stuffed data bits, packet framing, and USB bus-reset detection.
- Feeds the packet/PID receiver.

---
 rtl/usb_fs_pkg.sv | 23 ++
 rtl/usb_nrzi_unstuff.sv | 49 ++++
 rtl/usb_fs_rx_bit_recovery.sv | 187 ++++++++++++++++++
 tb/tb_usb_fs_rx_bit_recovery.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_fs_pkg.sv
// Shared line-state codes, receiver FSM encodings and default timing for the FS receive path.
// Pure declarations: no latency, no flow control.
package usb_fs_pkg;

  // {dn,dp} as sampled on the bus
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_EOP    = 2'b10
  } rx_state_t;

  localparam int USB_OVERSAMPLE   = 4;
  localparam int USB_STUFF_LEN    = 6;
  localparam int USB_RESET_CYCLES = 120;

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// NRZI decoder and bit de-stuffer; owns the previous line state and the run-of-ones count.
// Combinational outputs in the strobe cycle (parent registers them); no backpressure.
module usb_nrzi_unstuff
  import usb_fs_pkg::*;
#(
  parameter int STUFF_LEN = USB_STUFF_LEN
) (
  input  logic        i_clk,
  input  logic        i_strobe,
  input  line_state_t i_state,
  input  logic        i_clear,
  output logic        o_bit_valid,
  output logic        o_bit_data,
  output logic        o_stuff_err
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);

  line_state_t   r_prev;
  logic [OW-1:0] r_ones;
  logic          w_bit;
  logic          w_at_stuff;

  // No transition between bit cells decodes as a 1
  assign w_bit      = (i_state == r_prev);
  assign w_at_stuff = (r_ones == ONES_MAX);

  always_comb begin
    o_bit_valid = i_strobe && !w_at_stuff;
    o_bit_data  = w_bit;
    o_stuff_err = i_strobe && w_at_stuff && w_bit;
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_prev <= LS_J;
      r_ones <= '0;
    end else if (i_strobe) begin
      r_prev <= i_state;
      if (w_at_stuff || !w_bit) begin
        r_ones <= '0;
      end else begin
        r_ones <= r_ones + 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_fs_rx_bit_recovery.sv
// FS USB rx bit recovery: 4x phase counter, NRZI/unstuff, framing FSM, bus-reset timer; all outputs 1 clk after strobe.
// No backpressure (line-rate stream); optional saturating error counter under USB_FS_RX_ERR_CNT_EN.
module usb_fs_rx_bit_recovery
  import usb_fs_pkg::*;
#(
  parameter int OVERSAMPLE   = USB_OVERSAMPLE,
  parameter int STUFF_LEN    = USB_STUFF_LEN,
  parameter int RESET_CYCLES = USB_RESET_CYCLES
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_dp,
  input  logic       i_dn,
  input  logic       i_line_edge,
  output logic [1:0] o_line_state,
  output logic       o_bit_valid,
  output logic       o_bit_data,
  output logic       o_pkt_active,
  output logic       o_eop,
  output logic       o_stuff_err,
  output logic       o_line_err,
  output logic       o_usb_reset
`ifdef USB_FS_RX_ERR_CNT_EN
  ,
  output logic [7:0] o_err_count
`endif
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam logic [PW-1:0] MID     = PW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] SE0_MAX = CW'(RESET_CYCLES);

  logic [PW-1:0] r_phase;
  logic [CW-1:0] r_se0_cnt;
  rx_state_t     r_state;
  line_state_t   r_line_state;
  logic          r_bit_valid;
  logic          r_bit_data;
  logic          r_pkt_active;
  logic          r_eop;
  logic          r_stuff_err;
  logic          r_line_err;
  logic          r_usb_reset;

  line_state_t   w_ls;
  logic          w_se0;
  logic          w_strobe;
  logic          w_dec;
  logic          w_clear;
  logic          w_bit_valid;
  logic          w_bit_data;
  logic          w_stuff_err;
  logic [CW-1:0] w_se0_nxt;

  assign w_ls     = line_state_t'({i_dn, i_dp});
  assign w_se0    = !i_dp && !i_dn;
  // An edge landing on the sample point realigns the phase and defers the sample
  assign w_strobe = (r_phase == MID) && !i_line_edge;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phase <= '0;
    end else if (i_line_edge) begin
      r_phase <= PW'(1);
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  assign w_dec = w_strobe &&
                 (((r_state == ST_IDLE) && (w_ls == LS_K)) ||
                  ((r_state == ST_ACTIVE) && ((w_ls == LS_J) || (w_ls == LS_K))));

  // Any return to IDLE re-arms the decoder with prev=J and no ones counted
  assign w_clear = i_reset ||
                   (w_strobe &&
                    (((r_state == ST_ACTIVE) && ((w_ls == LS_SE1) || w_stuff_err)) ||
                     ((r_state == ST_EOP) && (w_ls != LS_SE0))));

  usb_nrzi_unstuff #(
    .STUFF_LEN (STUFF_LEN)
  ) u_nrzi_unstuff (
    .i_clk       (i_clk),
    .i_strobe    (w_dec),
    .i_state     (w_ls),
    .i_clear     (w_clear),
    .o_bit_valid (w_bit_valid),
    .o_bit_data  (w_bit_data),
    .o_stuff_err (w_stuff_err)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_line_state <= LS_J;
      r_bit_valid  <= 1'b0;
      r_bit_data   <= 1'b0;
      r_pkt_active <= 1'b0;
      r_eop        <= 1'b0;
      r_stuff_err  <= 1'b0;
      r_line_err   <= 1'b0;
    end else begin
      r_bit_valid <= w_bit_valid;
      r_bit_data  <= w_bit_valid && w_bit_data;
      r_stuff_err <= w_stuff_err;
      r_eop       <= 1'b0;
      r_line_err  <= 1'b0;
      if (w_strobe) begin
        r_line_state <= w_ls;
        case (r_state)
          ST_IDLE: begin
            if (w_ls == LS_K) begin
              r_state      <= ST_ACTIVE;
              r_pkt_active <= 1'b1;
            end
          end
          ST_ACTIVE: begin
            if (w_ls == LS_SE0) begin
              r_state <= ST_EOP;
            end else if ((w_ls == LS_SE1) || w_stuff_err) begin
              r_line_err   <= (w_ls == LS_SE1);
              r_state      <= ST_IDLE;
              r_pkt_active <= 1'b0;
            end
          end
          ST_EOP: begin
            if (w_ls == LS_J) begin
              r_eop        <= 1'b1;
              r_state      <= ST_IDLE;
              r_pkt_active <= 1'b0;
            end else if (w_ls != LS_SE0) begin
              r_line_err   <= 1'b1;
              r_state      <= ST_IDLE;
              r_pkt_active <= 1'b0;
            end
          end
          default: begin
            r_state      <= ST_IDLE;
            r_pkt_active <= 1'b0;
          end
        endcase
      end
    end
  end

  // Bus-reset timer runs every clk, independent of bit timing
  assign w_se0_nxt = !w_se0 ? '0 :
                     (r_se0_cnt == SE0_MAX) ? SE0_MAX : r_se0_cnt + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_se0_cnt   <= '0;
      r_usb_reset <= 1'b0;
    end else begin
      r_se0_cnt   <= w_se0_nxt;
      r_usb_reset <= (w_se0_nxt == SE0_MAX);
    end
  end

`ifdef USB_FS_RX_ERR_CNT_EN
  logic [7:0] r_err_count;
  logic [8:0] w_err_sum;

  assign w_err_sum = {1'b0, r_err_count} + {8'd0, r_stuff_err} + {8'd0, r_line_err};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err_count <= '0;
    end else begin
      r_err_count <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
    end
  end

  assign o_err_count = r_err_count;
`endif

  assign o_line_state = r_line_state;
  assign o_bit_valid  = r_bit_valid;
  assign o_bit_data   = r_bit_data;
  assign o_pkt_active = r_pkt_active;
  assign o_eop        = r_eop;
  assign o_stuff_err  = r_stuff_err;
  assign o_line_err   = r_line_err;
  assign o_usb_reset  = r_usb_reset;

endmodule

// File: tb/tb_usb_fs_rx_bit_recovery.sv
// Directed bench for usb_fs_rx_bit_recovery: sync/payload, stuffing, stuff/line errors, EOP, bus reset, mid-packet reset.
module tb_usb_fs_rx_bit_recovery;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dp = 1'b1;
  logic       dn = 1'b0;
  logic       line_edge = 1'b0;
  logic [1:0] line_state;
  logic       bit_valid;
  logic       bit_data;
  logic       pkt_active;
  logic       eop;
  logic       stuff_err;
  logic       line_err;
  logic       usb_reset;
`ifdef USB_FS_RX_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  int   n_pass  = 0;
  int   n_total = 0;
  int   n_eop   = 0;
  int   n_stuff = 0;
  int   n_lerr  = 0;
  logic q_bits[$];
  logic [1:0] cur = 2'b01;

  always #5 clk = ~clk;

  usb_fs_rx_bit_recovery dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_dp         (dp),
    .i_dn         (dn),
    .i_line_edge  (line_edge),
    .o_line_state (line_state),
    .o_bit_valid  (bit_valid),
    .o_bit_data   (bit_data),
    .o_pkt_active (pkt_active),
    .o_eop        (eop),
    .o_stuff_err  (stuff_err),
    .o_line_err   (line_err),
    .o_usb_reset  (usb_reset)
`ifdef USB_FS_RX_ERR_CNT_EN
    ,
    .o_err_count  (err_count)
`endif
  );

  // Record output pulses just after each active edge
  always begin
    @(posedge clk);
    #1;
    if (bit_valid) q_bits.push_back(bit_data);
    if (eop) n_eop++;
    if (stuff_err) n_stuff++;
    if (line_err) n_lerr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bits(input string tag, input logic [31:0] exp, input int n);
    chk({tag, "_nbits"}, 32'(q_bits.size()), 32'(n));
    for (int i = 0; i < n && i < q_bits.size(); i++)
      chk({tag, "_bit"}, 32'(q_bits[i]), 32'(exp[n-1-i]));
    q_bits.delete();
  endtask

  // One bit cell of 4 clk, starting at a negedge
  task automatic sym(input logic [1:0] s, input logic force_edge);
    line_edge = force_edge || ({dn, dp} != s);
    {dn, dp}  = s;
    @(negedge clk);
    line_edge = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic nbit(input logic b);
    if (!b) cur = (cur == 2'b01) ? 2'b10 : 2'b01;
    sym(cur, 1'b0);
  endtask

  task automatic send_sync();
    cur = 2'b01;
    repeat (7) nbit(1'b0);
    nbit(1'b1);
  endtask

  task automatic end_pkt(input string tag);
    sym(2'b00, 1'b0);
    sym(2'b00, 1'b0);
    line_edge = 1'b1;
    {dn, dp}  = 2'b01;
    @(negedge clk);
    line_edge = 1'b0;
    @(negedge clk);
    chk({tag, "_eop_before"}, 32'(eop), 0);
    chk({tag, "_pkt_before"}, 32'(pkt_active), 1);
    @(negedge clk);
    chk({tag, "_eop_pulse"}, 32'(eop), 1);
    chk({tag, "_pkt_after"}, 32'(pkt_active), 0);
    @(negedge clk);
    chk({tag, "_eop_single"}, 32'(eop), 0);
    cur = 2'b01;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_line_state", 32'(line_state), 32'h1);
    chk("rst_bit_valid", 32'(bit_valid), 0);
    chk("rst_pkt_active", 32'(pkt_active), 0);
    chk("rst_eop", 32'(eop), 0);
    chk("rst_stuff_err", 32'(stuff_err), 0);
    chk("rst_line_err", 32'(line_err), 0);
    chk("rst_usb_reset", 32'(usb_reset), 0);
    reset = 1'b0;

    // Idle J with spurious edges every 4 clk
    repeat (4) sym(2'b01, 1'b1);
    chk("idle_line_state", 32'(line_state), 32'h1);
    chk("idle_pkt_active", 32'(pkt_active), 0);
    chk("idle_usb_reset", 32'(usb_reset), 0);
    chk_bits("idle", 0, 0);

    // SYNC KJKJKJKK with pkt_active timing on the first K, then payload 1,0,1,1,0
    cur = 2'b10;
    line_edge = 1'b1;
    {dn, dp}  = cur;
    @(negedge clk);
    line_edge = 1'b0;
    @(negedge clk);
    chk("sync_pkt_pre", 32'(pkt_active), 0);
    @(negedge clk);
    chk("sync_pkt_rise", 32'(pkt_active), 1);
    chk("sync_line_state_k", 32'(line_state), 32'h2);
    @(negedge clk);
    repeat (6) nbit(1'b0);
    nbit(1'b1);
    nbit(1'b1); nbit(1'b0); nbit(1'b1); nbit(1'b1); nbit(1'b0);
    end_pkt("pktB");
    chk_bits("pktB", 13'b0000000_1_10110, 13);
    chk("pktB_neop", 32'(n_eop), 1);
    chk("pktB_nstuff", 32'(n_stuff), 0);
    chk("pktB_nlerr", 32'(n_lerr), 0);
`ifdef USB_FS_RX_ERR_CNT_EN
    chk("pktB_errcnt", 32'(err_count), 0);
`endif

    // Six ones, stuffed 0 dropped, then real 0,1
    send_sync();
    nbit(1'b0);
    repeat (6) nbit(1'b1);
    nbit(1'b0);
    nbit(1'b0);
    nbit(1'b1);
    end_pkt("pktC");
    chk_bits("pktC", 17'b0000000_1_0_111111_0_1, 17);
    chk("pktC_nstuff", 32'(n_stuff), 0);
    chk("pktC_neop", 32'(n_eop), 2);

    // Seventh identical state after six ones
    send_sync();
    nbit(1'b0);
    repeat (6) nbit(1'b1);
    nbit(1'b1);
    sym(2'b01, 1'b0);
    sym(2'b01, 1'b0);
    chk_bits("stuff", 15'b0000000_1_0_111111, 15);
    chk("stuff_nstuff", 32'(n_stuff), 1);
    chk("stuff_pkt_active", 32'(pkt_active), 0);
    chk("stuff_neop", 32'(n_eop), 2);

    // SE1 inside a packet
    send_sync();
    sym(2'b11, 1'b0);
    chk("se1_line_state", 32'(line_state), 32'h3);
    sym(2'b01, 1'b0);
    sym(2'b01, 1'b0);
    chk_bits("se1", 8'b0000000_1, 8);
    chk("se1_nlerr", 32'(n_lerr), 1);
    chk("se1_pkt_active", 32'(pkt_active), 0);
    chk("se1_neop", 32'(n_eop), 2);
    chk("se1_nstuff", 32'(n_stuff), 1);
`ifdef USB_FS_RX_ERR_CNT_EN
    chk("se1_errcnt", 32'(err_count), 2);
`endif

    // Bus reset: 119 clk of SE0 is not enough, 120 is
    line_edge = 1'b1;
    {dn, dp}  = 2'b00;
    @(negedge clk);
    line_edge = 1'b0;
    repeat (118) @(negedge clk);
    chk("busrst_119", 32'(usb_reset), 0);
    @(negedge clk);
    chk("busrst_120", 32'(usb_reset), 1);
    repeat (10) @(negedge clk);
    chk("busrst_hold", 32'(usb_reset), 1);
    chk("busrst_line_state", 32'(line_state), 32'h0);
    line_edge = 1'b1;
    {dn, dp}  = 2'b01;
    @(negedge clk);
    line_edge = 1'b0;
    chk("busrst_release", 32'(usb_reset), 0);
    repeat (7) @(negedge clk);
    chk("busrst_pkt_active", 32'(pkt_active), 0);
    chk("busrst_neop", 32'(n_eop), 2);
    chk_bits("busrst", 0, 0);

    // Reset asserted right before a payload bit would be registered
    send_sync();
    nbit(1'b1);
    line_edge = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_pkt_before", 32'(pkt_active), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_line_state", 32'(line_state), 32'h1);
    chk("midrst_bit_valid", 32'(bit_valid), 0);
    chk("midrst_pkt_active", 32'(pkt_active), 0);
    chk("midrst_eop", 32'(eop), 0);
    chk("midrst_stuff_err", 32'(stuff_err), 0);
    chk("midrst_line_err", 32'(line_err), 0);
    chk("midrst_usb_reset", 32'(usb_reset), 0);
`ifdef USB_FS_RX_ERR_CNT_EN
    chk("midrst_errcnt", 32'(err_count), 0);
`endif
    reset = 1'b0;
    repeat (3) sym(2'b01, 1'b1);
    chk_bits("midrst", 9'b0000000_11, 9);
    chk("midrst_neop", 32'(n_eop), 2);
    chk("midrst_pkt_idle", 32'(pkt_active), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
